// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc_sequencer block: FSM state encoding,
// next-PC select codes, default PC step and trap vector, branch offset helper.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StUpdate = 3'd4,
        StHalt   = 3'd5
    } pc_state_e;

    typedef enum logic [1:0] {
        SelSeq    = 2'd0,
        SelBranch = 2'd1,
        SelJump   = 2'd2,
        SelTrap   = 2'd3
    } pc_sel_e;

    localparam logic [31:0] PC_STEP     = 32'd4;
    localparam logic [31:0] TRAP_VECTOR = 32'h0000_0080;

    // Word offset to byte offset: sign-extend and scale by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of PC register, instruction memory and decode/execute handshake
// signals seen by pc_sequencer. master = sequencer side, slave = environment.
interface pc_sequencer_if;

    logic [31:0] pc_cur;
    logic        imem_req;
    logic        imem_ack;
    logic        ir_we;
    logic        is_branch;
    logic        is_jump;
    logic        is_halt;
    logic        illegal_op;
    logic [15:0] imm16;
    logic [25:0] jtarget26;
    logic        exec_start;
    logic        exec_done;
    logic        branch_taken;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        halted;
    logic        trap;
    logic [31:0] epc;

    modport master (
        input  pc_cur, imem_ack, is_branch, is_jump, is_halt, illegal_op, imm16, jtarget26,
               exec_done, branch_taken,
        output imem_req, ir_we, exec_start, pc_we, pc_next, halted, trap, epc
    );

    modport slave (
        output pc_cur, imem_ack, is_branch, is_jump, is_halt, illegal_op, imm16, jtarget26,
               exec_done, branch_taken,
        input  imem_req, ir_we, exec_start, pc_we, pc_next, halted, trap, epc
    );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC target selection: sequential, branch, jump or trap.
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] PcStep     = PC_STEP,
    parameter logic [31:0] TrapVector = TRAP_VECTOR
) (
    input  logic [31:0] pc_cur_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] jtarget26_i,
    input  pc_sel_e     sel_i,
    output logic [31:0] target_o
);

    logic [31:0] pc_plus4;
    assign pc_plus4 = pc_cur_i + 32'd4;

    // Target mux; all sums wrap modulo 2^32.
    always_comb begin
        target_o = '0;
        unique case (sel_i)
            SelSeq:    target_o = pc_cur_i + PcStep;
            SelBranch: target_o = pc_plus4 + branch_offset(imm16_i);
            SelJump:   target_o = {pc_plus4[31:28], jtarget26_i, 2'b00};
            SelTrap:   target_o = TrapVector;
            default:   target_o = '0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/decode/execute/update sequencer that owns the PC register
// write enable and next value. Optional illegal-opcode trap support is built
// when the PC_TRAP_EN macro is defined; otherwise trap and epc are tied to 0.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] PcStep     = PC_STEP,
    parameter logic [31:0] TrapVector = TRAP_VECTOR
) (
    input  logic           CLK,
    input  logic           reset,
    pc_sequencer_if.master bus
);

    pc_state_e   state_q, state_d;
    logic        is_branch_q, is_jump_q;
    logic [15:0] imm16_q;
    logic [25:0] jtarget26_q;
    logic        exec_issued_q;
    logic [31:0] pc_next_q, pc_next_d;
    pc_sel_e     sel;
    logic [31:0] target;
    logic        trap_take;

`ifdef PC_TRAP_EN
    assign trap_take = bus.illegal_op;
`else
    assign trap_take = 1'b0;
`endif

    pc_next_calc #(
        .PcStep     (PcStep),
        .TrapVector (TrapVector)
    ) u_calc (
        .pc_cur_i    (bus.pc_cur),
        .imm16_i     (imm16_q),
        .jtarget26_i (jtarget26_q),
        .sel_i       (sel),
        .target_o    (target)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack/done are only looked at in their own states.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (bus.imem_ack) state_d = StDecode;
            StDecode: begin
                if (bus.is_halt)      state_d = StHalt;
                else if (trap_take)   state_d = StUpdate;
                else                  state_d = StExec;
            end
            StExec:   if (bus.exec_done) state_d = StUpdate;
            StUpdate: state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // Next-PC select: a trap can only be taken from DECODE, so it outranks the rest.
    always_comb begin
        sel = SelSeq;
        if (state_q == StDecode)                   sel = SelTrap;
        else if (is_jump_q)                        sel = SelJump;
        else if (is_branch_q && bus.branch_taken)  sel = SelBranch;
    end

    // pc_next is captured on the transition into UPDATE and held afterwards.
    always_comb begin
        pc_next_d = pc_next_q;
        if ((state_q == StExec && bus.exec_done) ||
            (state_q == StDecode && !bus.is_halt && trap_take)) begin
            pc_next_d = target;
        end
    end

    // Decoded fields, execute-issued flag and next-PC register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            is_branch_q   <= 1'b0;
            is_jump_q     <= 1'b0;
            imm16_q       <= '0;
            jtarget26_q   <= '0;
            exec_issued_q <= 1'b0;
            pc_next_q     <= '0;
        end else begin
            if (state_q == StDecode) begin
                is_branch_q <= bus.is_branch;
                is_jump_q   <= bus.is_jump;
                imm16_q     <= bus.imm16;
                jtarget26_q <= bus.jtarget26;
            end
            exec_issued_q <= (state_q == StExec);
            pc_next_q     <= pc_next_d;
        end
    end

`ifdef PC_TRAP_EN
    logic        trap_q;
    logic [31:0] epc_q;

    // trap_q is high for exactly the UPDATE cycle that follows a trapping DECODE.
    always_ff @(posedge CLK) begin
        if (reset) begin
            trap_q <= 1'b0;
            epc_q  <= '0;
        end else begin
            trap_q <= (state_q == StDecode) && !bus.is_halt && trap_take;
            if (state_q == StDecode && !bus.is_halt && trap_take) begin
                epc_q <= bus.pc_cur;
            end
        end
    end

    assign bus.trap = trap_q;
    assign bus.epc  = epc_q;
`else
    assign bus.trap = 1'b0;
    assign bus.epc  = '0;
`endif

    // Moore-style outputs decoded from state; ir_we follows ack within FETCH.
    always_comb begin
        bus.imem_req   = (state_q == StFetch);
        bus.ir_we      = (state_q == StFetch) && bus.imem_ack;
        bus.exec_start = (state_q == StExec) && !exec_issued_q;
        bus.pc_we      = (state_q == StUpdate);
        bus.halted     = (state_q == StHalt);
    end

    assign bus.pc_next = pc_next_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer. Covers the PC_TRAP_EN build
// when the macro is defined and the default build otherwise.
module tb_pc_sequencer;

    logic CLK = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    pc_sequencer_if bus_if ();

    pc_sequencer dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.pc_cur       = '0;
        bus_if.imem_ack     = 1'b0;
        bus_if.is_branch    = 1'b0;
        bus_if.is_jump      = 1'b0;
        bus_if.is_halt      = 1'b0;
        bus_if.illegal_op   = 1'b0;
        bus_if.imm16        = '0;
        bus_if.jtarget26    = '0;
        bus_if.exec_done    = 1'b0;
        bus_if.branch_taken = 1'b0;
    endtask

    // Leaves the DUT in IDLE with reset released; the next edge enters FETCH.
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    // Plays memory and execute unit for one instruction, starting the cycle
    // before FETCH and returning in the UPDATE cycle (bounded to 40 cycles).
    task automatic run_instr(input int ack_dly, input int done_dly, output logic ok,
                             output int cyc, output int reqs, output int starts,
                             output int irwes, output int traps, output logic [31:0] nxt);
        logic in_exec = 1'b0;
        int   ecnt = 0;
        ok = 1'b0; cyc = 0; reqs = 0; starts = 0; irwes = 0; traps = 0; nxt = 'x;
        for (int i = 0; i < 40; i++) begin
            step();
            cyc++;
            if (bus_if.imem_req) begin
                reqs++;
                bus_if.imem_ack = (reqs > ack_dly);
            end else begin
                bus_if.imem_ack = 1'b0;
            end
            if (bus_if.exec_start) begin
                in_exec = 1'b1;
                ecnt = 0;
                starts++;
            end
            if (in_exec) begin
                ecnt++;
                bus_if.exec_done = (ecnt > done_dly);
            end else begin
                bus_if.exec_done = 1'b0;
            end
            #1;
            if (bus_if.ir_we) irwes++;
            if (bus_if.trap) traps++;
            if (bus_if.exec_done) in_exec = 1'b0;
            if (bus_if.pc_we) begin
                ok = 1'b1;
                nxt = bus_if.pc_next;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        bus_if.imem_ack  = 1'b1;
        bus_if.exec_done = 1'b1;
        step();
        step();
        checks++;
        if ({bus_if.imem_req, bus_if.ir_we, bus_if.exec_start, bus_if.pc_we,
             bus_if.halted, bus_if.trap} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus_if.imem_req, bus_if.ir_we, bus_if.exec_start, bus_if.pc_we,
                      bus_if.halted, bus_if.trap});
        end
        checks++;
        if (bus_if.pc_next !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc_next: got %h expected 00000000", bus_if.pc_next);
        end
        checks++;
        if (bus_if.epc !== 32'h0) begin
            errors++;
            $display("FAIL reset_epc: got %h expected 00000000", bus_if.epc);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic ok; int cyc, reqs, starts, irwes, traps; logic [31:0] nxt;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            run_instr(0, 0, ok, cyc, reqs, starts, irwes, traps, nxt);
            checks++;
            if (!ok || cyc != 4) begin
                errors++;
                $display("FAIL seq_period[%0d]: got ok=%0b cyc=%0d expected ok=1 cyc=4",
                         k, ok, cyc);
            end
            checks++;
            if (nxt !== 32'(4 * (k + 1))) begin
                errors++;
                $display("FAIL seq_pc_next[%0d]: got %h expected %h", k, nxt, 32'(4 * (k + 1)));
            end
            checks++;
            if (reqs != 1 || starts != 1 || irwes != 1) begin
                errors++;
                $display("FAIL seq_strobes[%0d]: got req=%0d start=%0d irwe=%0d expected 1 1 1",
                         k, reqs, starts, irwes);
            end
            bus_if.pc_cur = nxt;  // PC register model
        end
        step();
        checks++;
        if (bus_if.pc_we !== 1'b0 || bus_if.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL seq_after_update: got we=%b req=%b expected we=0 req=1",
                     bus_if.pc_we, bus_if.imem_req);
        end
    endtask

    task automatic test_wrap();
        logic ok; int cyc, reqs, starts, irwes, traps; logic [31:0] nxt;
        do_reset();
        bus_if.pc_cur = 32'hFFFF_FFFC;
        run_instr(0, 0, ok, cyc, reqs, starts, irwes, traps, nxt);
        checks++;
        if (!ok || nxt !== 32'h0) begin
            errors++;
            $display("FAIL seq_wrap: got %h expected 00000000", nxt);
        end
    endtask

    task automatic test_branch();
        logic ok; int cyc, reqs, starts, irwes, traps; logic [31:0] nxt;
        do_reset();
        bus_if.pc_cur       = 32'h100;
        bus_if.is_branch    = 1'b1;
        bus_if.imm16        = 16'hFFFF;
        bus_if.branch_taken = 1'b1;
        run_instr(0, 0, ok, cyc, reqs, starts, irwes, traps, nxt);
        checks++;
        if (!ok || nxt !== 32'h100) begin
            errors++;
            $display("FAIL branch_taken: got %h expected 00000100", nxt);
        end
        bus_if.branch_taken = 1'b0;
        run_instr(0, 0, ok, cyc, reqs, starts, irwes, traps, nxt);
        checks++;
        if (!ok || nxt !== 32'h104) begin
            errors++;
            $display("FAIL branch_not_taken: got %h expected 00000104", nxt);
        end
        bus_if.branch_taken = 1'b1;
        bus_if.imm16        = 16'h0010;
        run_instr(0, 0, ok, cyc, reqs, starts, irwes, traps, nxt);
        checks++;
        if (!ok || nxt !== 32'h144) begin
            errors++;
            $display("FAIL branch_forward: got %h expected 00000144", nxt);
        end
    endtask

    task automatic test_jump();
        logic ok; int cyc, reqs, starts, irwes, traps; logic [31:0] nxt;
        do_reset();
        bus_if.pc_cur    = 32'h1000_0000;
        bus_if.is_jump   = 1'b1;
        bus_if.jtarget26 = 26'h40;
        run_instr(0, 0, ok, cyc, reqs, starts, irwes, traps, nxt);
        checks++;
        if (!ok || nxt !== 32'h1000_0100) begin
            errors++;
            $display("FAIL jump: got %h expected 10000100", nxt);
        end
        bus_if.is_branch    = 1'b1;
        bus_if.branch_taken = 1'b1;
        bus_if.imm16        = 16'h0010;
        run_instr(0, 0, ok, cyc, reqs, starts, irwes, traps, nxt);
        checks++;
        if (!ok || nxt !== 32'h1000_0100) begin
            errors++;
            $display("FAIL jump_over_branch: got %h expected 10000100", nxt);
        end
        bus_if.is_branch = 1'b0;
        bus_if.pc_cur    = 32'h0FFF_FFFC;
        bus_if.jtarget26 = 26'h0;
        run_instr(0, 0, ok, cyc, reqs, starts, irwes, traps, nxt);
        checks++;
        if (!ok || nxt !== 32'h1000_0000) begin
            errors++;
            $display("FAIL jump_region: got %h expected 10000000", nxt);
        end
    endtask

    task automatic test_wait_states();
        logic ok; int cyc, reqs, starts, irwes, traps; logic [31:0] nxt;
        do_reset();
        bus_if.pc_cur = 32'h40;
        run_instr(3, 2, ok, cyc, reqs, starts, irwes, traps, nxt);
        checks++;
        if (!ok || cyc != 9) begin
            errors++;
            $display("FAIL wait_period: got ok=%0b cyc=%0d expected ok=1 cyc=9", ok, cyc);
        end
        checks++;
        if (reqs != 4 || starts != 1 || irwes != 1) begin
            errors++;
            $display("FAIL wait_strobes: got req=%0d start=%0d irwe=%0d expected 4 1 1",
                     reqs, starts, irwes);
        end
        checks++;
        if (nxt !== 32'h44) begin
            errors++;
            $display("FAIL wait_pc_next: got %h expected 00000044", nxt);
        end
    endtask

    task automatic test_reset_in_exec();
        int we_cnt = 0;
        do_reset();
        bus_if.imem_ack = 1'b1;
        step();
        if (bus_if.pc_we) we_cnt++;
        step();
        if (bus_if.pc_we) we_cnt++;
        step();
        checks++;
        if (bus_if.exec_start !== 1'b1) begin
            errors++;
            $display("FAIL rst_exec_start: got %b expected 1", bus_if.exec_start);
        end
        reset = 1'b1;
        bus_if.exec_done = 1'b1;
        step();
        checks++;
        if ({bus_if.imem_req, bus_if.exec_start, bus_if.pc_we} !== 3'b000) begin
            errors++;
            $display("FAIL rst_exec_idle: got %b expected 000",
                     {bus_if.imem_req, bus_if.exec_start, bus_if.pc_we});
        end
        reset = 1'b0;
        bus_if.imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus_if.pc_we) we_cnt++;
        end
        checks++;
        if (bus_if.imem_req !== 1'b1 || bus_if.exec_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_exec_refetch: got req=%b start=%b expected req=1 start=0",
                     bus_if.imem_req, bus_if.exec_start);
        end
        checks++;
        if (we_cnt != 0) begin
            errors++;
            $display("FAIL rst_exec_no_we: got %0d expected 0", we_cnt);
        end
    endtask

    task automatic test_halt();
        do_reset();
        bus_if.is_halt   = 1'b1;
        bus_if.imem_ack  = 1'b1;
        bus_if.exec_done = 1'b1;
        step();
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({bus_if.imem_req, bus_if.pc_we, bus_if.exec_start, bus_if.halted} !== 4'b0001)
            begin
                errors++;
                $display("FAIL halt[%0d]: got %b expected 0001", i,
                         {bus_if.imem_req, bus_if.pc_we, bus_if.exec_start, bus_if.halted});
            end
            step();
        end
    endtask

    task automatic test_illegal();
        logic ok; int cyc, reqs, starts, irwes, traps; logic [31:0] nxt;
        do_reset();
        bus_if.pc_cur     = 32'h200;
        bus_if.illegal_op = 1'b1;
        run_instr(0, 0, ok, cyc, reqs, starts, irwes, traps, nxt);
`ifdef PC_TRAP_EN
        checks++;
        if (!ok || cyc != 3 || starts != 0) begin
            errors++;
            $display("FAIL trap_path: got ok=%0b cyc=%0d start=%0d expected 1 3 0",
                     ok, cyc, starts);
        end
        checks++;
        if (nxt !== 32'h80 || traps != 1) begin
            errors++;
            $display("FAIL trap_target: got pc=%h traps=%0d expected 00000080 1", nxt, traps);
        end
        checks++;
        if (bus_if.epc !== 32'h200) begin
            errors++;
            $display("FAIL trap_epc: got %h expected 00000200", bus_if.epc);
        end
        step();
        checks++;
        if (bus_if.trap !== 1'b0) begin
            errors++;
            $display("FAIL trap_pulse: got %b expected 0", bus_if.trap);
        end
`else
        checks++;
        if (!ok || cyc != 4 || starts != 1 || traps != 0) begin
            errors++;
            $display("FAIL illegal_ignored: got ok=%0b cyc=%0d start=%0d traps=%0d exp 1 4 1 0",
                     ok, cyc, starts, traps);
        end
        checks++;
        if (nxt !== 32'h204 || bus_if.epc !== 32'h0) begin
            errors++;
            $display("FAIL illegal_seq: got pc=%h epc=%h expected 00000204 00000000",
                     nxt, bus_if.epc);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_branch();
        test_jump();
        test_wait_states();
        test_reset_in_exec();
        test_halt();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
